// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared sizing constants for the RAM-backed FIFO controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_DATA_W = 8;
    localparam int c_ADDR_W = 4;
    localparam int c_DEPTH  = 2 ** c_ADDR_W;

endpackage
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_fifo_ctrl
// Description : FIFO controller driving an external single-port RAM with a
//               registered read port, plus one registered output word.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W,
    parameter int DEPTH  = c_DEPTH      // must equal 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] c_LEVEL_FULL = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              pending_q, pending_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic w_rd_issue;
    logic w_wr_fire;

    // Reads win the single RAM port; in_ready therefore sees out_ready combinationally.
    always_comb begin
        w_rd_issue = (level_q != '0) && !pending_q && (!out_valid_q || out_ready);
        in_ready   = !rst && (level_q != c_LEVEL_FULL) && !w_rd_issue;
        w_wr_fire  = in_valid && in_ready;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        pending_d   = w_rd_issue;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (w_wr_fire) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            level_d  = level_q + (ADDR_W+1)'(1);
        end
        if (w_rd_issue) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            level_d  = level_q - (ADDR_W+1)'(1);
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        // ram_rdata is only meaningful in the cycle right after a read issue.
        if (pending_q) begin
            out_valid_d = 1'b1;
            out_data_d  = ram_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pending_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign ram_wr_en = w_wr_fire;
    assign ram_addr  = w_wr_fire ? wr_ptr_q : rd_ptr_q;
    assign ram_wdata = w_wr_fire ? in_data : '0;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign level     = level_q;
    assign full      = (level_q == c_LEVEL_FULL);
    assign empty     = (level_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_fifo_ctrl
// Description : Randomised bench for ram_fifo_ctrl against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       ram_wr_en;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic [4:0] level;
    logic       full;
    logic       empty;

    ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ram_wr_en (ram_wr_en),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    // 16x8 RAM with registered (read-before-write) data output
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int first_wr = -1;
    int first_ov = -1;
    bit chk_en   = 1'b0;
    bit last_acc = 1'b0;
    logic [7:0] src_q [$];
    logic [7:0] pop_q [$];
    logic [7:0] exp_q [$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: stored words as a queue, one in-flight word, one output word.
    logic [7:0] mq [$];
    bit         m_pend;
    logic [7:0] m_pw;
    bit         m_ov;
    logic [7:0] m_od;
    int         m_wp;
    int         m_rp;

    function automatic bit m_rd();
        return (mq.size() > 0) && !m_pend && (!m_ov || out_ready);
    endfunction

    function automatic bit m_in_ready();
        return !rst && (mq.size() < 16) && !m_rd();
    endfunction

    initial forever @(posedge clk) cyc++;

    initial forever begin
        bit rd, wr;
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            m_pend = 1'b0; m_pw = '0; m_ov = 1'b0; m_od = '0;
            m_wp = 0; m_rp = 0;
        end else begin
            rd = m_rd();
            wr = in_valid && m_in_ready();
            if (m_ov && out_ready) m_ov = 1'b0;
            if (m_pend) begin
                m_ov = 1'b1; m_od = m_pw; m_pend = 1'b0;
            end
            if (rd) begin
                m_pend = 1'b1; m_pw = mq.pop_front(); m_rp = (m_rp + 1) % 16;
            end
            if (wr) begin
                mq.push_back(in_data); m_wp = (m_wp + 1) % 16;
            end
        end
    end

    // Compare process: checks every mid-cycle against the model.
    initial forever begin
        bit e_wr;
        @(negedge clk);
        last_acc = in_valid && in_ready;
        if (!rst) begin
            if (out_valid && out_ready) pop_q.push_back(out_data);
            if (ram_wr_en && first_wr < 0) first_wr = cyc;
            if (out_valid && first_ov < 0) first_ov = cyc;
        end
        if (chk_en && !rst) begin
            e_wr = in_valid && m_in_ready();
            chk("in_ready",  32'(in_ready),  32'(m_in_ready()));
            chk("ram_wr_en", 32'(ram_wr_en), 32'(e_wr));
            chk("ram_addr",  32'(ram_addr),  32'(e_wr ? m_wp : m_rp));
            chk("ram_wdata", 32'(ram_wdata), e_wr ? 32'(in_data) : 32'd0);
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            if (m_ov) chk("out_data", 32'(out_data), 32'(m_od));
            chk("level", 32'(level), 32'(mq.size()));
            chk("full",  32'(full),  32'(mq.size() == 16));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
        end
    end

    // Offers src_q words in order; pv/pr are percent probabilities for in_valid/out_ready.
    task automatic run(int ncyc, int pv, int pr);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            if (last_acc && src_q.size() > 0) void'(src_q.pop_front());
            in_valid  = (src_q.size() > 0) && ($urandom_range(99) < pv);
            in_data   = (src_q.size() > 0) ? src_q[0] : 8'h00;
            out_ready = ($urandom_range(99) < pr);
        end
    endtask

    task automatic chk_pops(string nm);
        chk({nm, "_count"}, 32'(pop_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < pop_q.size(); i++)
            chk(nm, 32'(pop_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        chk("rst_level",     32'(level),     32'd0);
        chk("rst_empty",     32'(empty),     32'd1);
        chk("rst_full",      32'(full),      32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_wr_en",     32'(ram_wr_en), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // Three words in order; out_valid lands 3 cycles after the first write
        src_q = '{8'h11, 8'h22, 8'h33};
        exp_q = '{8'h11, 8'h22, 8'h33};
        pop_q.delete();
        run(15, 100, 100);
        chk_pops("basic_order");
        chk("first_latency", 32'(first_ov - first_wr), 32'd3);

        // Fill with the output stalled: 17 words fit, the 18th is held off
        src_q.delete(); exp_q.delete(); pop_q.delete();
        for (int i = 0; i < 18; i++) begin
            src_q.push_back(8'(8'h60 + i));
            exp_q.push_back(8'(8'h60 + i));
        end
        run(30, 100, 0);
        @(negedge clk);
        chk("fill_level",    32'(level),       32'd16);
        chk("fill_full",     32'(full),        32'd1);
        chk("fill_in_ready", 32'(in_ready),    32'd0);
        chk("fill_left",     32'(src_q.size()), 32'd1);
        run(5, 100, 0);
        @(negedge clk);
        chk("stall_out_data", 32'(out_data), 32'h60);
        chk("stall_level",    32'(level),    32'd16);
        chk("stall_left",     32'(src_q.size()), 32'd1);
        run(80, 100, 100);
        chk_pops("fill_order");

        // Random streaming traffic, pointers wrap several times
        src_q.delete(); exp_q.delete(); pop_q.delete();
        for (int i = 0; i < 40; i++) begin
            logic [7:0] v;
            v = 8'($urandom_range(255));
            src_q.push_back(v);
            exp_q.push_back(v);
        end
        run(400, 60, 50);
        run(80, 0, 100);
        chk_pops("stream_order");

        // Async reset while a read is in flight with 5 words stored
        src_q.delete();
        for (int i = 0; i < 7; i++) src_q.push_back(8'(8'h80 + i));
        run(20, 100, 0);
        @(negedge clk);
        chk("pre_rst_level", 32'(level), 32'd6);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("pend_level", 32'(level), 32'd5);
        #2;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_level",     32'(level),     32'd0);
        chk("arst_empty",     32'(empty),     32'd1);
        chk("arst_wr_en",     32'(ram_wr_en), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        pop_q.delete();
        src_q = '{8'hA5};
        exp_q = '{8'hA5};
        chk_en = 1'b1;
        run(12, 100, 100);
        chk_pops("post_rst");

        // in_valid during a read-issue cycle is held off by one cycle
        pop_q.delete();
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
        @(negedge clk);
        chk("coll_w1_ready", 32'(in_ready),  32'd1);
        chk("coll_w1_wr",    32'(ram_wr_en), 32'd1);
        @(posedge clk); #1;
        in_data = 8'hC3;
        @(negedge clk);
        chk("coll_rd_ready", 32'(in_ready),  32'd0);
        chk("coll_rd_wr",    32'(ram_wr_en), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("coll_w2_wr",    32'(ram_wr_en), 32'd1);
        chk("coll_w2_wdata", 32'(ram_wdata), 32'hC3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q = '{8'h5A, 8'hC3};
        run(12, 0, 100);
        chk_pops("coll_order");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
